// File: rtl/tma_pkg.sv
// Shared types and limits for the TMA model-memory arbiter.
package tma_pkg;

  typedef enum logic [1:0] {
    ARB_OPEN,
    ARB_INFER,
    ARB_DRAIN
  } arb_state_t;

  typedef enum logic {
    OWN_HOST,
    OWN_DEC
  } owner_t;

  localparam int TMA_ARB_MAX_RD_LAT = 4;

endpackage

// File: rtl/tma_rd_tag_pipe.sv
// Owner tag pipeline: follows each SRAM read for RD_LAT cycles so that the
// returning data can be routed to the requester that issued the read.
module tma_rd_tag_pipe
  import tma_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  owner_t owner,
  output logic   out_valid,
  output owner_t out_owner,
  output logic   any_valid
);

  logic [RD_LAT-1:0] r_valid;
  owner_t            r_owner [RD_LAT];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's old value and the shift is order-independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= push;
      for (int i = 1; i < RD_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  // NOTE: owner tags are only meaningful under their valid bit, so they carry
  // no reset; keeping them out of the reset block avoids a needless reset mux.
  always_ff @(posedge clk) begin
    r_owner[0] <= owner;
    for (int i = 1; i < RD_LAT; i++) begin
      r_owner[i] <= r_owner[i-1];
    end
  end

  assign out_valid = r_valid[RD_LAT-1];
  assign out_owner = r_owner[RD_LAT-1];
  assign any_valid = |r_valid;

endmodule

// File: rtl/tma_model_mem_arbiter.sv
// Single-port model SRAM arbiter between host loader and clause decoder.
// Optional build macro TMA_ARB_STALL_CNT_EN adds a host stall counter.
module tma_model_mem_arbiter
  import tma_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int RD_LAT         = 1,
  parameter int HOST_BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inf_active,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              dec_req,
  input  logic [ADDR_W-1:0] dec_addr,
  output logic              dec_gnt,
  output logic              dec_rvalid,
  output logic [DATA_W-1:0] dec_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef TMA_ARB_STALL_CNT_EN
  input  logic              stall_cnt_clr,
  output logic [15:0]       host_stall_cnt,
`endif
  output logic              arb_busy
);

  localparam int CNT_W = $clog2(HOST_BURST_MAX + 1);

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_starve_cnt;

  logic   w_starve;
  logic   w_host_gnt;
  logic   w_dec_gnt;
  logic   w_rd_push;
  owner_t w_push_owner;
  logic   w_tag_valid;
  owner_t w_tag_owner;
  logic   w_any_valid;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    w_starve   = 1'b0;
    w_host_gnt = 1'b0;
    w_dec_gnt  = 1'b0;
    if (!rst) begin
      case (r_state)
        ARB_OPEN: begin
          w_starve   = (r_starve_cnt == CNT_W'(HOST_BURST_MAX)) && dec_req;
          w_host_gnt = host_req && !w_starve;
          w_dec_gnt  = dec_req && !w_host_gnt;
        end
        ARB_INFER: w_dec_gnt = dec_req;
        default: ;
      endcase
    end
  end

  assign host_gnt  = w_host_gnt;
  assign dec_gnt   = w_dec_gnt;
  assign mem_cs    = w_host_gnt || w_dec_gnt;
  assign mem_we    = w_host_gnt && host_we;
  assign mem_addr  = w_host_gnt ? host_addr : (w_dec_gnt ? dec_addr : '0);
  assign mem_wdata = w_host_gnt ? host_wdata : '0;

  assign w_rd_push    = (w_host_gnt && !host_we) || w_dec_gnt;
  assign w_push_owner = w_dec_gnt ? OWN_DEC : OWN_HOST;

  // The state only moves on the edge, so the cycle inf_active rises still
  // arbitrates under open rules and a host access granted then completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_OPEN;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        ARB_OPEN:  if (inf_active)   r_state <= ARB_INFER;
        ARB_INFER: if (!inf_active)  r_state <= ARB_DRAIN;
        ARB_DRAIN: if (!w_any_valid) r_state <= ARB_OPEN;
        default:                     r_state <= ARB_OPEN;
      endcase

      if (r_state != ARB_OPEN || w_dec_gnt || !dec_req) begin
        r_starve_cnt <= '0;
      end else if (w_host_gnt) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

  tma_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .push      (w_rd_push),
    .owner     (w_push_owner),
    .out_valid (w_tag_valid),
    .out_owner (w_tag_owner),
    .any_valid (w_any_valid)
  );

  assign host_rvalid = w_tag_valid && (w_tag_owner == OWN_HOST);
  assign dec_rvalid  = w_tag_valid && (w_tag_owner == OWN_DEC);
  assign host_rdata  = host_rvalid ? mem_rdata : '0;
  assign dec_rdata   = dec_rvalid ? mem_rdata : '0;
  assign arb_busy    = (r_state != ARB_OPEN);

`ifdef TMA_ARB_STALL_CNT_EN
  logic [15:0] r_host_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || stall_cnt_clr) begin
      r_host_stall_cnt <= '0;
    end else if (host_req && !w_host_gnt && r_host_stall_cnt != 16'hFFFF) begin
      r_host_stall_cnt <= r_host_stall_cnt + 16'd1;
    end
  end

  assign host_stall_cnt = r_host_stall_cnt;
`endif

endmodule

// File: tb/tb_tma_model_mem_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic compared every
// cycle against a transaction-level model of the arbiter.
module tb_tma_model_mem_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 3;
  localparam int HBM    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              inf_active = 1'b0;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_gnt, host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              dec_req = 1'b0;
  logic [ADDR_W-1:0] dec_addr = '0;
  logic              dec_gnt, dec_rvalid;
  logic [DATA_W-1:0] dec_rdata;
  logic              mem_cs, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              arb_busy;
`ifdef TMA_ARB_STALL_CNT_EN
  logic              stall_cnt_clr = 1'b0;
  logic [15:0]       host_stall_cnt;
`endif

  always #5 clk = ~clk;

  tma_model_mem_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .RD_LAT         (RD_LAT),
    .HOST_BURST_MAX (HBM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .inf_active     (inf_active),
    .host_req       (host_req),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_gnt       (host_gnt),
    .host_rvalid    (host_rvalid),
    .host_rdata     (host_rdata),
    .dec_req        (dec_req),
    .dec_addr       (dec_addr),
    .dec_gnt        (dec_gnt),
    .dec_rvalid     (dec_rvalid),
    .dec_rdata      (dec_rdata),
    .mem_cs         (mem_cs),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
`ifdef TMA_ARB_STALL_CNT_EN
    .stall_cnt_clr  (stall_cnt_clr),
    .host_stall_cnt (host_stall_cnt),
`endif
    .arb_busy       (arb_busy)
  );

  // SRAM macro stand-in with RD_LAT read latency and junk on idle cycles.
  logic [DATA_W-1:0] sram    [4096];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  bit                rd_v    [RD_LAT];

  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) begin
      rd_pipe[i] <= rd_pipe[i-1];
      rd_v[i]    <= rd_v[i-1];
    end
    rd_pipe[0] <= sram[mem_addr];
    rd_v[0]    <= mem_cs && !mem_we;
    if (mem_cs && mem_we) sram[mem_addr] <= mem_wdata;
  end

  assign mem_rdata = rd_v[RD_LAT-1] ? rd_pipe[RD_LAT-1] : 32'h5A5A_5A5A;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: mode 0=open, 1=inference, 2=drain.
  typedef struct {
    int          due;
    bit          host;
    logic [31:0] data;
  } rd_t;

  rd_t         pend[$];
  logic [31:0] ref_mem [64];
  int          m_mode = 0;
  int          m_cnt  = 0;
  int          cyc    = 0;
  bit          m_hg   = 1'b0;
  bit          m_dg   = 1'b0;

  always @(negedge clk) begin : model
    bit          eh, ed, starve, hv, dv, empty;
    logic [31:0] hd, dd, ew;
    logic [11:0] ea;
    cyc++;
    if (rst) begin
      m_mode = 0;
      m_cnt  = 0;
      pend.delete();
      m_hg = 1'b0;
      m_dg = 1'b0;
    end else begin
      eh     = 1'b0;
      ed     = 1'b0;
      starve = (m_mode == 0) && (m_cnt == HBM) && dec_req;
      if (m_mode == 0) begin
        eh = host_req && !starve;
        ed = dec_req && !eh;
      end else if (m_mode == 1) begin
        ed = dec_req;
      end
      ea = eh ? host_addr : (ed ? dec_addr : 12'h000);
      ew = eh ? host_wdata : 32'h0;

      empty = (pend.size() == 0);
      hv = 1'b0; dv = 1'b0; hd = '0; dd = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (pend[0].host) begin hv = 1'b1; hd = pend[0].data; end
        else              begin dv = 1'b1; dd = pend[0].data; end
        void'(pend.pop_front());
      end

      check("grants",    {host_gnt, dec_gnt}, {eh, ed});
      check("mem_ctl",   {mem_cs, mem_we}, {eh | ed, eh && host_we});
      check("mem_addr",  mem_addr, ea);
      check("mem_wdata", mem_wdata, ew);
      check("host_rd",   {host_rvalid, host_rdata}, {hv, hd});
      check("dec_rd",    {dec_rvalid, dec_rdata}, {dv, dd});
      check("arb_busy",  arb_busy, m_mode != 0);

      if (eh && host_we) ref_mem[host_addr[5:0]] = host_wdata;
      if ((eh && !host_we) || ed) pend.push_back('{cyc + RD_LAT, eh, ref_mem[ea[5:0]]});

      if (m_mode != 0 || ed || !dec_req) m_cnt = 0;
      else if (eh) m_cnt++;

      if (m_mode == 0 && inf_active)       m_mode = 1;
      else if (m_mode == 1 && !inf_active) m_mode = 2;
      else if (m_mode == 2 && empty)       m_mode = 0;

      m_hg = eh;
      m_dg = ed;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", arb_busy, 1'b0);
    check("reset_outs", {mem_cs, mem_we, host_gnt, dec_gnt, host_rvalid, dec_rvalid}, 6'b0);
    tick();

    // Preload every address the traffic below touches.
    for (int a = 0; a < 64; a++) begin
      host_req = 1'b1; host_we = 1'b1; host_addr = 12'(a); host_wdata = $urandom;
      tick();
    end
    host_req = 1'b0;
    repeat (RD_LAT + 1) tick();

    // Write then read back through the host port.
    host_req = 1'b1; host_we = 1'b1; host_addr = 12'h010; host_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("s1_wr_gnt", {host_gnt, mem_we, mem_addr}, {1'b1, 1'b1, 12'h010});
    tick();
    host_we = 1'b0;
    @(negedge clk);
    check("s1_rd_gnt", {host_gnt, mem_cs, mem_we}, 3'b110);
    tick();
    host_req = 1'b0;
    for (int k = 1; k <= RD_LAT; k++) begin
      @(negedge clk);
      check("s1_rvalid", host_rvalid, k == RD_LAT);
      if (k == RD_LAT) check("s1_rdata", host_rdata, 32'hDEADBEEF);
      tick();
    end

    // Host burst limit lets a waiting decoder in after HBM grants.
    host_req = 1'b1; host_we = 1'b0; host_addr = 12'h030;
    dec_req  = 1'b1; dec_addr = 12'h020;
    for (int k = 1; k <= HBM; k++) begin
      @(negedge clk);
      check("s2_host_burst", {host_gnt, dec_gnt}, 2'b10);
      tick();
    end
    @(negedge clk);
    check("s2_dec_turn", {dec_gnt, host_gnt, mem_addr}, {1'b1, 1'b0, 12'h020});
    tick();
    dec_req = 1'b0;
    @(negedge clk);
    check("s2_host_resume", host_gnt, 1'b1);
    tick();
    host_req = 1'b0;
    repeat (RD_LAT + 1) tick();

    // Inference start, decoder ownership, then drain.
    host_req = 1'b1; host_we = 1'b1; host_addr = 12'h011; host_wdata = $urandom;
    inf_active = 1'b1;
    @(negedge clk);
    check("s3_last_host", {host_gnt, arb_busy}, 2'b10);
    tick();
    host_we = 1'b0; host_addr = 12'h012;
    dec_req = 1'b1; dec_addr = 12'h005;
    @(negedge clk);
    check("s3_infer_dec", {dec_gnt, host_gnt, arb_busy}, 3'b101);
    tick();
    dec_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("s3_host_blocked", {host_gnt, arb_busy}, 2'b01);
      tick();
    end
    dec_req = 1'b1; dec_addr = 12'h006;
    @(negedge clk);
    check("s4_dec_last", dec_gnt, 1'b1);
    tick();
    dec_req = 1'b0; inf_active = 1'b0;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      check("s4_drain", {host_gnt, arb_busy}, 2'b01);
      check("s4_dec_rvalid", dec_rvalid, k == RD_LAT);
      tick();
    end
    @(negedge clk);
    check("s4_open_host", {host_gnt, arb_busy}, 2'b10);
    tick();
    host_req = 1'b0;
    repeat (RD_LAT + 1) tick();

    // Reset right after a decoder read grant drops the read.
    inf_active = 1'b1;
    tick();
    dec_req = 1'b1; dec_addr = 12'h007;
    @(negedge clk);
    check("s5_dec_gnt", dec_gnt, 1'b1);
    tick();
    dec_req = 1'b0; rst = 1'b1; inf_active = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      check("s5_no_rvalid", {dec_rvalid, host_rvalid, arb_busy, mem_cs}, 4'b0);
      tick();
    end

`ifdef TMA_ARB_STALL_CNT_EN
    stall_cnt_clr = 1'b1;
    inf_active    = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 12'h001;
    repeat (20) tick();
    @(negedge clk);
    check("stall_cnt_20", host_stall_cnt, 16'd20);
    tick();
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    @(negedge clk);
    check("stall_cnt_clr", host_stall_cnt, 16'd0);
    tick();
    inf_active = 1'b0;
    repeat (6) tick();
    host_req = 1'b0;
    repeat (RD_LAT + 1) tick();
`endif

    // Random traffic; requests are held until the model says they were taken.
    for (int n = 0; n < 3000; n++) begin
      if (!host_req || m_hg) begin
        host_req   = ($urandom_range(0, 2) != 0);
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = 12'($urandom_range(0, 63));
        host_wdata = $urandom;
      end
      if (!dec_req || m_dg) begin
        dec_req  = ($urandom_range(0, 1) == 1);
        dec_addr = 12'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 24) == 0) begin
        if (!inf_active)   inf_active = 1'b1;
        else if (!dec_req) inf_active = 1'b0;
      end
      tick();
    end

    host_req = 1'b0; dec_req = 1'b0; inf_active = 1'b0;
    repeat (RD_LAT + 8) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tma_model_mem_arbiter.md
Name: tma_model_mem_arbiter

Overview:
- Shares the single-port model SRAM (clause/weight store) between two requesters: the host configuration loader (read/write) and the clause decoder (read-only).
- Inference state from the accelerator controller (decode active) gives the decoder exclusive ownership. Host accesses are blocked until in-flight decoder reads have drained.
- Sits between the TMA controller/decoder and the model SRAM macro.
- Returns read data to the owner that issued each read, using an owner tag pipeline.

Parameters:
- ADDR_W, 12, SRAM word address width.
- DATA_W, 32, SRAM data width.
- RD_LAT, 1, SRAM read latency in cycles; legal range 1..4.
- HOST_BURST_MAX, 8, maximum consecutive host grants while a decoder request waits in the open state.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inf_active  in  1  high while inference decoding runs (driven from decode_en)
- host_req  in  1  host access request; held until granted
- host_we  in  1  1=write, 0=read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access issued this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- dec_req  in  1  decoder read request; held until granted
- dec_addr  in  ADDR_W  decoder address
- dec_gnt  out  1  decoder read issued this cycle
- dec_rvalid  out  1  decoder read data valid
- dec_rdata  out  DATA_W  decoder read data
- mem_cs  out  1  SRAM chip select
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, RD_LAT cycles after a read cs
- arb_busy  out  1  state is not ARB_OPEN

Behaviour:
- Grants are combinational from the requests and the registered state. At most one grant per cycle. mem_* is driven from the granted requester in the same cycle.
- No grant: mem_cs=0, mem_we=0, and mem_addr/mem_wdata=0.
- States:
  - ARB_OPEN: host has priority.
  - ARB_INFER: decoder only.
  - ARB_DRAIN: no grants.
- Transitions:
  - OPEN->INFER when inf_active=1.
  - INFER->DRAIN when inf_active=0.
  - DRAIN->OPEN when the tag pipe holds no valid entries.
  - The state register updates on the clock edge. Grants in the cycle inf_active rises are still computed under OPEN rules, so a host access granted in that cycle completes.
- Starvation counter (width clog2(HOST_BURST_MAX+1)), OPEN only:
  - Increments on each cycle with host_gnt && dec_req.
  - Clears on dec_gnt or when dec_req=0.
  - When it equals HOST_BURST_MAX and dec_req=1, the decoder is granted instead of the host.
- Host writes use mem_we=1 and produce no rvalid. A host request in INFER/DRAIN stalls with host_gnt=0 until OPEN.
- Tag pipe:
  - RD_LAT-deep shift register of {valid, owner}.
  - A read grant pushes {1, owner}.
  - The stage-RD_LAT output drives host_rvalid or dec_rvalid (never both).
  - host_rdata and dec_rdata are both driven from mem_rdata, qualified by the matching rvalid.
- Decoder requests are never granted in DRAIN. The decoder must only request while inf_active is high.
- Reset values:
  - state=ARB_OPEN, counter=0, tag pipe cleared.
  - All gnt/rvalid outputs and mem_cs/mem_we are 0; arb_busy=0.
- Reset mid-operation: in-flight reads are dropped and no rvalid is produced afterwards.
- Simultaneous host_req and dec_req in OPEN below threshold: host wins.
- Simultaneous host_req and dec_req in INFER: decoder wins; host_gnt=0.

Optional Feature:
- Macro TMA_ARB_STALL_CNT_EN.
- When defined:
  - Adds output host_stall_cnt [15:0], a saturating count (stops at 16'hFFFF) of cycles with host_req=1 && host_gnt=0.
  - Adds input stall_cnt_clr, a synchronous clear that takes priority over increment.
  - Reset value 0.
- When undefined: neither port exists and no counter logic is present.

Decomposition:
- tma_pkg holds:
  - typedef enum logic [1:0] arb_state_t {ARB_OPEN, ARB_INFER, ARB_DRAIN}.
  - typedef enum logic owner_t {OWN_HOST, OWN_DEC}.
  - localparam TMA_ARB_MAX_RD_LAT=4.
- One sub-module: tma_rd_tag_pipe (params RD_LAT; inputs push and owner; outputs out_valid, out_owner, any_valid).

Test Plan:
- RD_LAT=1, OPEN: host write addr 0x010 data 0xDEADBEEF, then host read 0x010 -> host_gnt each cycle, host_rvalid one cycle after the read grant, host_rdata=0xDEADBEEF, dec_rvalid=0 throughout.
- OPEN, host_req held high continuously with dec_req=1 at addr 0x020, HOST_BURST_MAX=8 -> 8 host grants, then dec_gnt on cycle 9 with mem_addr=0x020, then host resumes.
- inf_active rises while host_req=1 -> host_gnt in that cycle only. Next cycle dec_req is granted, host_gnt=0 and arb_busy=1 until OPEN.
- RD_LAT=3, decoder read granted on the last inf_active cycle -> DRAIN lasts until dec_rvalid appears 3 cycles after the grant. A host_req during DRAIN is granted only on the first OPEN cycle.
- Reset asserted one cycle after a decoder read grant (RD_LAT=2) -> no dec_rvalid afterwards; state OPEN and all outputs 0.
- With TMA_ARB_STALL_CNT_EN: host_req blocked for 20 cycles in INFER -> host_stall_cnt=20. Pulse stall_cnt_clr -> 0. Force 16'hFFFF -> holds at 16'hFFFF.
